bin2bcd_seq: RTL

- Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly downstream of the rounding stage: consumes its 13-bit unsigned rounded magnitude (tenths units).
- Produces four packed BCD digits for the seven-segment display driver.
- Multi-cycle, one bit per clock, to keep area small; start/busy/done handshake to the display controller.

---
 rtl/bin2bcd_if.sv | 28 ++
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and data bus between the display controller and
// the sequential binary-to-BCD converter.
interface bin2bcd_if #(
   parameter int unsigned W      = 13,
   parameter int unsigned DIGITS = 4
);
   logic                  start;
   logic [W-1:0]          bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;

   modport master (
      output start,
      output bin_in,
      input  busy,
      input  done,
      input  bcd_out
   );

   modport slave (
      input  start,
      input  bin_in,
      output busy,
      output done,
      output bcd_out
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter, one input
// bit per clock; result lands in bcd_out together with a one-cycle done pulse.
module bin2bcd_seq #(
   parameter int unsigned W      = 13,
   parameter int unsigned DIGITS = 4
) (
   input logic      clk,
   input logic      rst_n,
   bin2bcd_if.slave bus
);

   localparam int unsigned CntW = $clog2(W + 1);
   localparam int unsigned BcdW = 4 * DIGITS;

   typedef enum logic [0:0] {StIdle, StConv} state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      shift_q, shift_d;
   logic [BcdW-1:0]   scratch_q, scratch_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;

   logic [BcdW-1:0]   adj;
   logic [BcdW-1:0]   scratch_nxt;

   // Per-digit add-3 with no carry between digits.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
      scratch_nxt = {adj[BcdW-2:0], shift_q[W-1]};
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (bus.start) begin
               shift_d   = bus.bin_in;
               scratch_d = '0;
               cnt_d     = CntW'(W);
               busy_d    = 1'b1;
               state_d   = StConv;
            end
         end
         StConv: begin
            scratch_d = scratch_nxt;
            shift_d   = {shift_q[W-2:0], 1'b0};
            cnt_d     = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               bcd_d   = scratch_nxt;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bcd_out = bcd_q;

endmodule
